// File: rtl/instr_fetch_sequencer_pkg.sv
// rtl/instr_fetch_sequencer_pkg.sv - shared state encoding and byte-lane constants for the fetch sequencer
package instr_fetch_pkg;

   typedef enum logic [2:0] {
      ST_RD0   = 3'd0,
      ST_RD1   = 3'd1,
      ST_RD2   = 3'd2,
      ST_LAST  = 3'd3,
      ST_HOLD  = 3'd4,
      ST_FAULT = 3'd5
   } state_e;

   localparam int INSTR_BYTES = 3;
   localparam int LANE_BITS   = 8;
   localparam int INSTR_W     = INSTR_BYTES * LANE_BITS;

   // Big-endian lanes: the byte at PC lands in the top lane.
   localparam int HI_MSB  = 23;
   localparam int HI_LSB  = 16;
   localparam int MID_MSB = 15;
   localparam int MID_LSB = 8;
   localparam int LO_MSB  = 7;
   localparam int LO_LSB  = 0;

endpackage

// File: rtl/instr_fetch_sequencer_if.sv
// rtl/instr_fetch_sequencer_if.sv - decode, loader and memory-port signals of the fetch sequencer
interface instr_fetch_sequencer_if #(
   parameter int ADDR_W = 24,
   parameter int BYTE_W = 8
);
   import instr_fetch_pkg::*;

   logic                          redirect;
   logic [ADDR_W-1:0]             start_pc;
   logic                          instr_valid;
   logic                          instr_ready;
   logic [INSTR_BYTES*BYTE_W-1:0] instruction;
   logic [ADDR_W-1:0]             instr_pc;
   logic                          load_valid;
   logic                          load_ready;
   logic [ADDR_W-1:0]             load_addr;
   logic [BYTE_W-1:0]             load_data;
   logic                          mem_en;
   logic                          mem_we;
   logic [ADDR_W-1:0]             mem_addr;
   logic [BYTE_W-1:0]             mem_wdata;
   logic [BYTE_W-1:0]             mem_rdata;
   logic                          fault;

   modport slave (
      input  redirect, start_pc, instr_ready, load_valid, load_addr, load_data, mem_rdata,
      output instr_valid, instruction, instr_pc, load_ready, mem_en, mem_we, mem_addr,
             mem_wdata, fault
   );

   modport master (
      output redirect, start_pc, instr_ready, load_valid, load_addr, load_data, mem_rdata,
      input  instr_valid, instruction, instr_pc, load_ready, mem_en, mem_we, mem_addr,
             mem_wdata, fault
   );

endinterface

// File: rtl/instr_fetch_sequencer_adder.sv
// rtl/instr_fetch_sequencer_adder.sv - ripple-carry adder used for the PC+1/+2/+3 offsets
module ripple_carry_adder #(
   parameter int W = 24
) (
   input  logic [W-1:0] a,
   input  logic [W-1:0] b,
   input  logic         cin,
   output logic [W-1:0] sum,
   output logic         cout
);

   always_comb begin
      logic c;
      c   = cin;
      sum = '0;
      for (int i = 0; i < W; i++) begin
         sum[i] = a[i] ^ b[i] ^ c;
         c      = (a[i] & b[i]) | (c & (a[i] ^ b[i]));
      end
      cout = c;
   end

endmodule

// File: rtl/instr_fetch_sequencer.sv
// rtl/instr_fetch_sequencer.sv - assembles 3-byte instructions from a byte memory and shares the port with a loader
module instr_fetch_sequencer
   import instr_fetch_pkg::*;
#(
   parameter int ADDR_W    = 24,
   parameter int MEM_DEPTH = 128,
   parameter int BYTE_W    = 8
) (
   input logic                     clk,
   input logic                     rst,
   instr_fetch_sequencer_if.slave  bus
);

   localparam logic [ADDR_W-1:0] LAST_FETCH_PC = ADDR_W'(MEM_DEPTH - INSTR_BYTES);
   localparam logic [ADDR_W-1:0] MEM_LIMIT     = ADDR_W'(MEM_DEPTH);

   state_e               state_q, state_d;
   logic [ADDR_W-1:0]    fetch_pc_q, fetch_pc_d;
   logic [ADDR_W-1:0]    instr_pc_q, instr_pc_d;
   logic [INSTR_W-1:0]   instr_q, instr_d;
   logic [INSTR_W-1:0]   asm_q, asm_d;
   logic                 instr_valid_q, instr_valid_d;
   logic                 fault_q, fault_d;

   logic [ADDR_W-1:0]    pc_p1, pc_p2, pc_p3;
   logic [2:0]           carry_unused;
   logic                 handshake;
   logic                 load_ready_c;
   logic                 load_grant;
   logic                 mem_en_c;
   logic                 mem_we_c;
   logic [ADDR_W-1:0]    mem_addr_c;
   logic [BYTE_W-1:0]    mem_wdata_c;

   ripple_carry_adder #(.W(ADDR_W)) u_add1 (
      .a(fetch_pc_q), .b(ADDR_W'(1)), .cin(1'b0), .sum(pc_p1), .cout(carry_unused[0])
   );
   ripple_carry_adder #(.W(ADDR_W)) u_add2 (
      .a(fetch_pc_q), .b(ADDR_W'(2)), .cin(1'b0), .sum(pc_p2), .cout(carry_unused[1])
   );
   ripple_carry_adder #(.W(ADDR_W)) u_add3 (
      .a(fetch_pc_q), .b(ADDR_W'(3)), .cin(1'b0), .sum(pc_p3), .cout(carry_unused[2])
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q       <= ST_RD0;
         fetch_pc_q    <= '0;
         instr_pc_q    <= '0;
         instr_q       <= '0;
         asm_q         <= '0;
         instr_valid_q <= 1'b0;
         fault_q       <= 1'b0;
      end else begin
         state_q       <= state_d;
         fetch_pc_q    <= fetch_pc_d;
         instr_pc_q    <= instr_pc_d;
         instr_q       <= instr_d;
         asm_q         <= asm_d;
         instr_valid_q <= instr_valid_d;
         fault_q       <= fault_d;
      end
   end

   always_comb begin
      state_d       = state_q;
      fetch_pc_d    = fetch_pc_q;
      instr_pc_d    = instr_pc_q;
      instr_d       = instr_q;
      asm_d         = asm_q;
      instr_valid_d = instr_valid_q;
      fault_d       = fault_q;
      mem_en_c      = 1'b0;
      mem_we_c      = 1'b0;
      mem_addr_c    = fetch_pc_q;
      mem_wdata_c   = bus.load_data;

      handshake    = instr_valid_q & bus.instr_ready;
      // Loader only gets the port between instructions so a fetch is never split.
      load_ready_c = !bus.redirect && (state_q inside {ST_RD0, ST_HOLD, ST_FAULT});
      load_grant   = load_ready_c & bus.load_valid;

      if (load_grant && (bus.load_addr < MEM_LIMIT)) begin
         mem_en_c   = 1'b1;
         mem_we_c   = 1'b1;
         mem_addr_c = bus.load_addr;
      end

      if (bus.redirect) begin
         state_d       = ST_RD0;
         fetch_pc_d    = bus.start_pc;
         instr_valid_d = 1'b0;
         fault_d       = 1'b0;
      end else begin
         case (state_q)
            ST_RD0: begin
               if (!load_grant) begin
                  if (fetch_pc_q > LAST_FETCH_PC) begin
                     state_d = ST_FAULT;
                     fault_d = 1'b1;
                  end else begin
                     mem_en_c   = 1'b1;
                     mem_addr_c = fetch_pc_q;
                     state_d    = ST_RD1;
                  end
               end
            end
            ST_RD1: begin
               asm_d[HI_MSB:HI_LSB] = bus.mem_rdata;
               mem_en_c             = 1'b1;
               mem_addr_c           = pc_p1;
               state_d              = ST_RD2;
            end
            ST_RD2: begin
               asm_d[MID_MSB:MID_LSB] = bus.mem_rdata;
               mem_en_c               = 1'b1;
               mem_addr_c             = pc_p2;
               state_d                = ST_LAST;
            end
            ST_LAST: begin
               asm_d[LO_MSB:LO_LSB] = bus.mem_rdata;
               instr_d              = asm_d;
               instr_pc_d           = fetch_pc_q;
               instr_valid_d        = 1'b1;
               state_d              = ST_HOLD;
            end
            ST_HOLD: begin
               if (handshake) begin
                  fetch_pc_d    = pc_p3;
                  instr_valid_d = 1'b0;
                  state_d       = ST_RD0;
               end
            end
            ST_FAULT: begin
               fault_d = 1'b1;
            end
            default: begin
               state_d = ST_RD0;
            end
         endcase
      end
   end

   assign bus.load_ready  = load_ready_c & ~rst;
   assign bus.mem_en      = mem_en_c & ~rst;
   assign bus.mem_we      = mem_we_c & ~rst;
   assign bus.mem_addr    = mem_addr_c;
   assign bus.mem_wdata   = mem_wdata_c;
   assign bus.instr_valid = instr_valid_q;
   assign bus.instruction = instr_q;
   assign bus.instr_pc    = instr_pc_q;
   assign bus.fault       = fault_q;

endmodule

// File: tb/tb_instr_fetch_sequencer.sv
// tb/tb_instr_fetch_sequencer.sv - directed and randomized bench for instr_fetch_sequencer
module tb_instr_fetch_sequencer;

   logic clk;
   logic rst;
   int   checks = 0;
   int   errors = 0;

   instr_fetch_sequencer_if #(.ADDR_W(24), .BYTE_W(8)) bus();

   instr_fetch_sequencer #(.ADDR_W(24), .MEM_DEPTH(128), .BYTE_W(8)) dut (
      .clk(clk),
      .rst(rst),
      .bus(bus.slave)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit exceeded");
      $fatal(1);
   end

   logic [7:0] mem [0:127];
   logic [7:0] gold [0:127];
   logic       pre_we = 1'b0;
   logic [6:0] pre_addr = '0;
   logic [7:0] pre_data = '0;
   logic       mon_en = 1'b0;
   logic [23:0] exp_pc = '0;
   logic [23:0] exp_instr = '0;
   logic        have_snap = 1'b0;
   int          reads_seen = 0;

   // Synchronous byte memory with one-cycle read latency.
   always @(posedge clk) begin
      if (pre_we) mem[pre_addr] <= pre_data;
      else if (bus.mem_en && (bus.mem_addr < 24'd128)) begin
         if (bus.mem_we) mem[bus.mem_addr[6:0]] <= bus.mem_wdata;
         else bus.mem_rdata <= mem[bus.mem_addr[6:0]];
      end
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [23:0] gold_word(input logic [23:0] pc);
      logic [23:0] p1, p2;
      p1 = pc + 24'd1;
      p2 = pc + 24'd2;
      return {gold[pc[6:0]], gold[p1[6:0]], gold[p2[6:0]]};
   endfunction

   // Reference model: byte image, expected fetch PC and the instruction visible at valid-rise.
   always @(negedge clk) begin
      logic [23:0] off;
      if (pre_we) gold[pre_addr] = pre_data;
      if (rst) begin
         exp_pc     = '0;
         have_snap  = 1'b0;
         reads_seen = 0;
      end else begin
         if (mon_en) begin
            chk("valid_and_fault", 32'(bus.instr_valid & bus.fault), 0);
            if (bus.redirect) begin
               chk("redirect_no_access", 32'(bus.mem_en), 0);
               chk("redirect_no_grant", 32'(bus.load_ready), 0);
            end
            if (bus.fault) chk("fault_only_out_of_range", 32'(exp_pc > 24'd125), 1);
            if (bus.mem_en && !bus.mem_we) begin
               off = bus.mem_addr - exp_pc;
               chk("read_window", 32'(off < 24'd3), 1);
               chk("read_in_range", 32'(bus.mem_addr < 24'd128), 1);
            end
            if (bus.load_valid && bus.load_ready)
               chk("grant_not_mid_fetch", 32'(reads_seen == 0 || bus.instr_valid), 1);
         end
         if (bus.instr_valid) begin
            if (!have_snap) begin
               exp_instr = gold_word(exp_pc);
               have_snap = 1'b1;
               if (mon_en) chk("valid_pc_in_range", 32'(exp_pc <= 24'd125), 1);
            end
            if (mon_en) begin
               chk("rand_instr_pc", 32'(bus.instr_pc), 32'(exp_pc));
               chk("rand_instruction", 32'(bus.instruction), 32'(exp_instr));
            end
         end
         if (bus.load_valid && bus.load_ready) begin
            if (bus.load_addr < 24'd128) begin
               if (mon_en) begin
                  chk("rand_wr_en", 32'({bus.mem_en, bus.mem_we}), 3);
                  chk("rand_wr_addr", 32'(bus.mem_addr), 32'(bus.load_addr));
                  chk("rand_wr_data", 32'(bus.mem_wdata), 32'(bus.load_data));
               end
               gold[bus.load_addr[6:0]] = bus.load_data;
            end else if (mon_en) begin
               chk("rand_oor_write_dropped", 32'(bus.mem_en), 0);
            end
         end
         if (bus.mem_en && !bus.mem_we) reads_seen++;
         if (bus.redirect) begin
            exp_pc     = bus.start_pc;
            have_snap  = 1'b0;
            reads_seen = 0;
         end else if (bus.instr_valid && bus.instr_ready) begin
            exp_pc     = exp_pc + 24'd3;
            have_snap  = 1'b0;
            reads_seen = 0;
         end
      end
   end

   task automatic cyc();
      @(posedge clk);
      #2;
   endtask

   task automatic poke(input logic [6:0] a, input logic [7:0] d);
      pre_we   = 1'b1;
      pre_addr = a;
      pre_data = d;
      cyc();
   endtask

   initial begin
      rst             = 1'b1;
      bus.redirect    = 1'b0;
      bus.start_pc    = '0;
      bus.instr_ready = 1'b0;
      bus.load_valid  = 1'b0;
      bus.load_addr   = '0;
      bus.load_data   = '0;
      cyc();
      for (int i = 0; i < 128; i++) poke(7'(i), 8'($urandom));
      poke(7'd0, 8'h12); poke(7'd1, 8'h34); poke(7'd2, 8'h56);
      poke(7'd3, 8'h9A); poke(7'd4, 8'hBC); poke(7'd5, 8'hDE);
      poke(7'd6, 8'h11); poke(7'd7, 8'h22); poke(7'd8, 8'h33);
      poke(7'd9, 8'hA1); poke(7'd10, 8'hB2); poke(7'd11, 8'hC3);
      poke(7'd125, 8'hC0); poke(7'd126, 8'hFF); poke(7'd127, 8'hEE);
      pre_we = 1'b0;

      // Reset state, loader asking during reset.
      bus.load_valid = 1'b1;
      bus.load_addr  = 24'd3;
      #1;
      chk("rst_load_ready", 32'(bus.load_ready), 0);
      chk("rst_mem_en", 32'(bus.mem_en), 0);
      chk("rst_instr_valid", 32'(bus.instr_valid), 0);
      chk("rst_fault", 32'(bus.fault), 0);
      chk("rst_instruction", 32'(bus.instruction), 0);
      chk("rst_instr_pc", 32'(bus.instr_pc), 0);
      bus.load_valid = 1'b0;

      // T1: first fetch, valid at cycle 4.
      cyc(); rst = 1'b0; #1;
      chk("t1_c0_read", 32'({bus.mem_en, bus.mem_we}), 2);
      chk("t1_c0_addr", 32'(bus.mem_addr), 0);
      cyc(); #1;
      chk("t1_c1_addr", 32'(bus.mem_addr), 1);
      cyc(); #1;
      chk("t1_c2_addr", 32'(bus.mem_addr), 2);
      cyc(); #1;
      chk("t1_c3_valid", 32'(bus.instr_valid), 0);
      chk("t1_c3_no_access", 32'(bus.mem_en), 0);
      cyc(); #1;
      chk("t1_c4_valid", 32'(bus.instr_valid), 1);
      chk("t1_instruction", 32'(bus.instruction), 'h123456);
      chk("t1_instr_pc", 32'(bus.instr_pc), 0);

      // T2: stall in HOLD.
      for (int i = 0; i < 10; i++) begin
         cyc(); #1;
         chk("t2_hold_valid", 32'(bus.instr_valid), 1);
         chk("t2_hold_instr", 32'(bus.instruction), 'h123456);
         chk("t2_hold_no_mem", 32'(bus.mem_en), 0);
      end
      bus.instr_ready = 1'b1;
      cyc(); bus.instr_ready = 1'b0; #1;
      chk("t2_next_read", 32'({bus.mem_en, bus.mem_we}), 2);
      chk("t2_next_addr", 32'(bus.mem_addr), 3);
      chk("t2_valid_dropped", 32'(bus.instr_valid), 0);

      // T3: loader held off during RD1..LAST, granted in HOLD.
      cyc();
      bus.load_valid = 1'b1; bus.load_addr = 24'd5; bus.load_data = 8'hAA; #1;
      chk("t3_rd1_no_grant", 32'(bus.load_ready), 0);
      chk("t3_rd1_addr", 32'(bus.mem_addr), 4);
      cyc(); #1;
      chk("t3_rd2_no_grant", 32'(bus.load_ready), 0);
      chk("t3_rd2_read", 32'({bus.mem_we, bus.mem_addr}), 5);
      cyc(); #1;
      chk("t3_last_no_grant", 32'(bus.load_ready), 0);
      chk("t3_last_no_mem", 32'(bus.mem_en), 0);
      cyc(); #1;
      chk("t3_hold_grant", 32'(bus.load_ready), 1);
      chk("t3_hold_write", 32'({bus.mem_en, bus.mem_we}), 3);
      chk("t3_wr_addr", 32'(bus.mem_addr), 5);
      chk("t3_wr_data", 32'(bus.mem_wdata), 'hAA);
      chk("t3_instr", 32'(bus.instruction), 'h9ABCDE);
      chk("t3_pc", 32'(bus.instr_pc), 3);
      cyc(); bus.load_addr = 24'd200; #1;
      chk("t3_mem5_written", 32'(mem[5]), 'hAA);
      chk("t3_instr_after_write", 32'(bus.instruction), 'h9ABCDE);
      chk("t3_oor_granted", 32'(bus.load_ready), 1);
      chk("t3_oor_no_mem", 32'(bus.mem_en), 0);
      bus.load_valid = 1'b0; bus.instr_ready = 1'b1;
      cyc(); bus.instr_ready = 1'b0;

      // Loader beats the RD0 read; RD0 retries the next cycle.
      bus.load_valid = 1'b1; bus.load_addr = 24'd7; bus.load_data = 8'h77; #1;
      chk("rd0_prio_grant", 32'(bus.load_ready), 1);
      chk("rd0_prio_write", 32'({bus.mem_en, bus.mem_we}), 3);
      chk("rd0_prio_addr", 32'(bus.mem_addr), 7);
      cyc(); bus.load_valid = 1'b0; #1;
      chk("rd0_retry_read", 32'({bus.mem_en, bus.mem_we}), 2);
      chk("rd0_retry_addr", 32'(bus.mem_addr), 6);
      cyc(); #1;
      chk("rd1_after_prio", 32'(bus.mem_addr), 7);

      // T4: redirect during RD2.
      cyc(); bus.redirect = 1'b1; bus.start_pc = 24'd9; bus.load_valid = 1'b1; #1;
      chk("t4_redirect_no_mem", 32'(bus.mem_en), 0);
      chk("t4_redirect_no_grant", 32'(bus.load_ready), 0);
      cyc(); bus.redirect = 1'b0; bus.load_valid = 1'b0; #1;
      chk("t4_new_read", 32'({bus.mem_en, bus.mem_we}), 2);
      chk("t4_new_addr", 32'(bus.mem_addr), 9);
      cyc(); cyc(); cyc(); cyc(); #1;
      chk("t4_valid", 32'(bus.instr_valid), 1);
      chk("t4_instr", 32'(bus.instruction), 'hA1B2C3);
      chk("t4_pc", 32'(bus.instr_pc), 9);
      chk("t4_mem7", 32'(mem[7]), 'h77);

      // T5: out-of-range start faults; redirect clears it.
      bus.redirect = 1'b1; bus.start_pc = 24'd126;
      cyc(); bus.redirect = 1'b0; #1;
      chk("t5_no_read", 32'(bus.mem_en), 0);
      cyc(); #1;
      chk("t5_fault", 32'(bus.fault), 1);
      chk("t5_fault_no_valid", 32'(bus.instr_valid), 0);
      for (int i = 0; i < 4; i++) begin
         cyc(); #1;
         chk("t5_fault_no_mem", 32'(bus.mem_en), 0);
         chk("t5_fault_sticky", 32'(bus.fault), 1);
      end
      bus.load_valid = 1'b1; bus.load_addr = 24'd20; bus.load_data = 8'h5A; #1;
      chk("t5_fault_grant", 32'(bus.load_ready), 1);
      chk("t5_fault_write", 32'({bus.mem_en, bus.mem_we}), 3);
      cyc(); bus.redirect = 1'b1; bus.start_pc = 24'd125; #1;
      chk("t5_redir_no_grant", 32'(bus.load_ready), 0);
      cyc(); bus.redirect = 1'b0; bus.load_valid = 1'b0; #1;
      chk("t5_fault_cleared", 32'(bus.fault), 0);
      chk("t5_edge_addr", 32'(bus.mem_addr), 125);
      chk("t5_edge_read", 32'({bus.mem_en, bus.mem_we}), 2);
      chk("t5_mem20", 32'(mem[20]), 'h5A);
      cyc(); cyc(); cyc(); cyc(); #1;
      chk("t5_edge_valid", 32'(bus.instr_valid), 1);
      chk("t5_edge_instr", 32'(bus.instruction), 'hC0FFEE);
      chk("t5_edge_pc", 32'(bus.instr_pc), 125);
      bus.instr_ready = 1'b1;
      cyc(); bus.instr_ready = 1'b0; #1;
      chk("t5_pc128_no_read", 32'(bus.mem_en), 0);
      cyc(); #1;
      chk("t5_pc128_fault", 32'(bus.fault), 1);
      bus.redirect = 1'b1; bus.start_pc = 24'd0;
      cyc(); bus.redirect = 1'b0; #1;
      chk("t5_recover_fault", 32'(bus.fault), 0);
      chk("t5_recover_addr", 32'(bus.mem_addr), 0);
      chk("t5_recover_read", 32'(bus.mem_en), 1);
      cyc(); cyc(); cyc(); cyc(); #1;
      chk("t5_recover_instr", 32'(bus.instruction), 'h123456);

      // T6: reset pulse during LAST.
      bus.redirect = 1'b1; bus.start_pc = 24'd3;
      cyc(); bus.redirect = 1'b0; #1;
      chk("t6_addr3", 32'(bus.mem_addr), 3);
      cyc(); cyc(); cyc();
      bus.load_valid = 1'b1; bus.load_addr = 24'd1; #1;
      chk("t6_last_no_grant", 32'(bus.load_ready), 0);
      rst = 1'b1; #1;
      chk("t6_rst_valid", 32'(bus.instr_valid), 0);
      chk("t6_rst_instr", 32'(bus.instruction), 0);
      chk("t6_rst_mem_en", 32'(bus.mem_en), 0);
      chk("t6_rst_load_ready", 32'(bus.load_ready), 0);
      cyc(); rst = 1'b0; bus.load_valid = 1'b0; #1;
      chk("t6_first_read", 32'({bus.mem_en, bus.mem_we}), 2);
      chk("t6_first_addr", 32'(bus.mem_addr), 0);
      cyc(); cyc(); cyc(); cyc(); #1;
      chk("t6_valid", 32'(bus.instr_valid), 1);
      chk("t6_instr", 32'(bus.instruction), 'h123456);
      chk("t6_pc", 32'(bus.instr_pc), 0);

      // Randomized traffic against the reference model.
      mon_en = 1'b1;
      for (int i = 0; i < 800; i++) begin
         bus.redirect    = ($urandom_range(0, 24) == 0);
         bus.start_pc    = 24'($urandom_range(0, 130));
         bus.instr_ready = 1'($urandom_range(0, 1));
         bus.load_valid  = ($urandom_range(0, 3) == 0);
         bus.load_addr   = 24'($urandom_range(0, 140));
         bus.load_data   = 8'($urandom);
         cyc();
      end
      bus.redirect = 1'b0; bus.instr_ready = 1'b0; bus.load_valid = 1'b0;
      for (int i = 0; i < 12; i++) begin
         cyc();
         if (bus.instr_valid || bus.fault) break;
      end
      #1;
      chk("settle_fault", 32'(bus.fault), 32'(exp_pc > 24'd125));
      chk("settle_valid", 32'(bus.instr_valid), 32'(exp_pc <= 24'd125));

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
